// File: rtl/apb_lint_pkg.sv
// Shared types for the APB-to-LINT bridge: FSM state encoding and LINT response opcodes.
package apb_lint_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ         = 2'd1,
    WAIT_RVALID = 2'd2,
    RESP        = 2'd3
  } state_e;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

endpackage

// File: rtl/apb_2_lint_tmo.sv
// Response timeout counter: counts cycles spent waiting for r_valid and flags the last allowed cycle.
module apb_2_lint_tmo #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_tmo;
    assign unused_tmo = clk ^ rst_n ^ clear ^ enable;
    assign expired    = 1'b0;
  end else begin : g_on
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Saturates at LAST so a stuck enable never wraps back to a non-expired value
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (clear) begin
        cnt <= '0;
      end else if (enable && (cnt != LAST)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign expired = (cnt == LAST);
  end

endmodule

// File: rtl/apb_2_lint.sv
// APB3 slave to LINT master bridge: one APB transfer becomes one LINT req/gnt/r_valid transaction.
module apb_2_lint
  import apb_lint_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int ID_WIDTH       = 10,
  parameter int AUX_WIDTH      = 8,
  parameter int ID_VALUE       = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] slave_PADDR,
  input  logic [DATA_WIDTH-1:0] slave_PWDATA,
  input  logic                  slave_PWRITE,
  input  logic                  slave_PSEL,
  input  logic                  slave_PENABLE,
  output logic [DATA_WIDTH-1:0] slave_PRDATA,
  output logic                  slave_PREADY,
  output logic                  slave_PSLVERR,
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [AUX_WIDTH-1:0]  data_aux_o,
  output logic [ID_WIDTH-1:0]   data_ID_o,
  input  logic                  data_gnt_i,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
  input  logic                  data_r_opc_i,
  input  logic [AUX_WIDTH-1:0]  data_r_aux_i,
  input  logic [ID_WIDTH-1:0]   data_r_ID_i
);

  localparam logic [ID_WIDTH-1:0] ID_C = ID_WIDTH'(ID_VALUE);

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic                  pready_q, pready_d;
  logic                  stale_q, stale_d;

  logic rsp_match;
  logic grant;
  logic tmo_exp;
  logic unused_in;

  assign rsp_match = data_r_valid_i && (data_r_ID_i == ID_C);
  assign grant     = (state_q == REQ) && req_q && data_gnt_i;
  assign unused_in = slave_PENABLE ^ (^data_r_aux_i);

  apb_2_lint_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (grant),
    .enable ((state_q == WAIT_RVALID) && !rsp_match),
    .expired(tmo_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (slave_PSEL) state_d = REQ;
      REQ:         if (req_q && data_gnt_i) state_d = WAIT_RVALID;
      WAIT_RVALID: if (rsp_match || tmo_exp) state_d = RESP;
      RESP:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // A timed-out transaction leaves its response owed by the interconnect; stale
  // blocks new requests until that late response has been swallowed.
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = wen_q;
    prdata_d  = '0;
    pslverr_d = OPC_OK;
    stale_d   = stale_q;
    if (stale_q && rsp_match) stale_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (slave_PSEL) begin
          addr_d  = slave_PADDR;
          wdata_d = slave_PWDATA;
          wen_d   = slave_PWRITE;
        end
      end
      WAIT_RVALID: begin
        if (rsp_match) begin
          prdata_d  = wen_q ? '0 : data_r_rdata_i;
          pslverr_d = data_r_opc_i;
        end else if (tmo_exp) begin
          pslverr_d = OPC_ERR;
          stale_d   = 1'b1;
        end
      end
      default: ;
    endcase
    req_d    = (state_d == REQ) && !stale_d;
    pready_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      pready_q  <= 1'b0;
      stale_q   <= 1'b0;
    end else begin
      req_q     <= req_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      pready_q  <= pready_d;
      stale_q   <= stale_d;
    end
  end

  assign slave_PRDATA  = prdata_q;
  assign slave_PREADY  = pready_q;
  assign slave_PSLVERR = pslverr_q;
  assign data_req_o    = req_q;
  assign data_add_o    = addr_q;
  assign data_wen_o    = wen_q;
  assign data_wdata_o  = wdata_q;
  assign data_be_o     = '1;
  assign data_aux_o    = '0;
  assign data_ID_o     = ID_C;

endmodule

// File: tb/tb_apb_2_lint.sv
// Bench for apb_2_lint: directed vector table, randomized transfers against a latency/result model, reset abort.
module tb_apb_2_lint;

  localparam int TMO = 8;
  localparam int IDV = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] slave_PADDR, slave_PWDATA, slave_PRDATA;
  logic        slave_PWRITE, slave_PSEL, slave_PENABLE, slave_PREADY, slave_PSLVERR;
  logic        data_req_o, data_wen_o, data_gnt_i, data_r_valid_i, data_r_opc_i;
  logic [31:0] data_add_o, data_wdata_o, data_r_rdata_i;
  logic [3:0]  data_be_o;
  logic [7:0]  data_aux_o, data_r_aux_i;
  logic [9:0]  data_ID_o, data_r_ID_i;

  int total = 0;
  int bad   = 0;
  bit stale = 1'b0;

  always #5 clk = ~clk;

  apb_2_lint #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .ID_WIDTH(10), .AUX_WIDTH(8),
    .ID_VALUE(IDV), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .slave_PADDR(slave_PADDR), .slave_PWDATA(slave_PWDATA), .slave_PWRITE(slave_PWRITE),
    .slave_PSEL(slave_PSEL), .slave_PENABLE(slave_PENABLE), .slave_PRDATA(slave_PRDATA),
    .slave_PREADY(slave_PREADY), .slave_PSLVERR(slave_PSLVERR),
    .data_req_o(data_req_o), .data_add_o(data_add_o), .data_wen_o(data_wen_o),
    .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_aux_o(data_aux_o),
    .data_ID_o(data_ID_o), .data_gnt_i(data_gnt_i), .data_r_valid_i(data_r_valid_i),
    .data_r_rdata_i(data_r_rdata_i), .data_r_opc_i(data_r_opc_i),
    .data_r_aux_i(data_r_aux_i), .data_r_ID_i(data_r_ID_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    int          gd;       // cycles req is held before gnt
    int          rd;       // WAIT cycles before the first response
    int          nbad;     // wrong-ID responses sent before the real one
    int          late_at;  // >0: cycle at which the owed late response is delivered
    logic [31:0] rdata;
    logic        opc;
    logic [31:0] exp_prdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_req"},     {31'd0, data_req_o},    32'd0);
    check({tag, "_pready"},  {31'd0, slave_PREADY},  32'd0);
    check({tag, "_pslverr"}, {31'd0, slave_PSLVERR}, 32'd0);
    check({tag, "_prdata"},  slave_PRDATA,           32'd0);
    check({tag, "_add"},     data_add_o,             32'd0);
    check({tag, "_wdata"},   data_wdata_o,           32'd0);
    check({tag, "_wen"},     {31'd0, data_wen_o},    32'd0);
    check({tag, "_consts"},  {10'd0, data_be_o, data_aux_o, data_ID_o}, {10'd0, 4'hF, 8'h00, 10'(IDV)});
  endtask

  // Protocol-level model: completion latency and APB result from the response timing alone.
  function automatic void model(inout vec_t v, inout bit stl);
    int idx;
    int shift;
    idx   = v.rd + v.nbad;
    shift = stl ? v.late_at : 0;
    if (idx >= TMO) begin
      v.exp_lat    = shift + 3 + v.gd + TMO - 1;
      v.exp_prdata = 32'd0;
      v.exp_err    = 1'b1;
      stl          = 1'b1;
    end else begin
      v.exp_lat    = shift + 3 + v.gd + idx;
      v.exp_prdata = v.wr ? 32'd0 : v.rdata;
      v.exp_err    = v.opc;
      stl          = 1'b0;
    end
  endfunction

  // Called at a negedge; acts as APB master and LINT responder for one transfer.
  task automatic run_xfer(input vec_t v, input string tag);
    int cyc, req_cyc, widx, lat;
    bit in_wait, done, pay_ok, hold_ok;
    logic [31:0] got_rd;
    logic got_err;
    cyc = 0; req_cyc = 0; widx = 0; lat = -1;
    in_wait = 0; done = 0; pay_ok = 1; hold_ok = 1;
    got_rd = '0; got_err = 1'b0;
    slave_PSEL = 1'b1; slave_PENABLE = 1'b0;
    slave_PADDR = v.addr; slave_PWDATA = v.wdata; slave_PWRITE = v.wr;
    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      slave_PENABLE  = 1'b1;
      data_gnt_i     = 1'b0;
      data_r_valid_i = 1'b0;
      data_r_ID_i    = 10'(IDV);
      data_r_rdata_i = $urandom;
      data_r_opc_i   = 1'($urandom);
      data_r_aux_i   = 8'($urandom);
      if (slave_PREADY) begin
        done = 1; lat = cyc; got_rd = slave_PRDATA; got_err = slave_PSLVERR;
      end else if (v.late_at > 0 && cyc <= v.late_at) begin
        if (data_req_o) hold_ok = 0;
        if (cyc == v.late_at) begin
          data_r_valid_i = 1'b1;
          data_r_opc_i   = 1'b0;
        end
      end else if (in_wait) begin
        if (data_req_o) pay_ok = 0;
        if (widx >= v.rd && widx < v.rd + v.nbad) begin
          data_r_valid_i = 1'b1;
          data_r_ID_i    = 10'(IDV ^ 1);
        end else if (widx == v.rd + v.nbad) begin
          data_r_valid_i = 1'b1;
          data_r_rdata_i = v.rdata;
          data_r_opc_i   = v.opc;
        end
        widx++;
      end else if (data_req_o) begin
        req_cyc++;
        if (data_add_o !== v.addr || data_wen_o !== v.wr || data_wdata_o !== v.wdata ||
            data_be_o !== 4'hF || data_aux_o !== 8'h00 || data_ID_o !== 10'(IDV)) pay_ok = 0;
        if (req_cyc == v.gd + 1) begin
          data_gnt_i = 1'b1;
          in_wait    = 1;
        end
      end
    end
    slave_PSEL = 1'b0; slave_PENABLE = 1'b0;
    data_gnt_i = 1'b0; data_r_valid_i = 1'b0;
    if (!done) check({tag, "_budget"}, 32'd0, 32'd1);
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_prdata"}, got_rd, v.exp_prdata);
    check({tag, "_pslverr"}, {31'd0, got_err}, {31'd0, v.exp_err});
    check({tag, "_req_cycles"}, req_cyc, v.gd + 1);
    check({tag, "_payload"}, {31'd0, pay_ok}, 32'd1);
    check({tag, "_holdoff"}, {31'd0, hold_ok}, 32'd1);
    @(negedge clk);
    check({tag, "_after"}, {slave_PRDATA[29:0], slave_PREADY, slave_PSLVERR}, 32'd0);
  endtask

  vec_t tbl[9];
  vec_t v;

  initial begin
    tbl[0] = '{32'h1A10_0004, 32'h0,         1'b0, 0, 0,  0, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 3};
    tbl[1] = '{32'h55AA_0011, 32'hA5A5_1234, 1'b1, 5, 0,  0, 0, 32'h1111_2222, 1'b0, 32'h0,         1'b0, 8};
    tbl[2] = '{32'h0000_0100, 32'h0,         1'b0, 1, 2,  0, 0, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 1'b1, 6};
    tbl[3] = '{32'h0000_0104, 32'h0,         1'b0, 0, 1,  0, 0, 32'h0000_1234, 1'b0, 32'h0000_1234, 1'b0, 4};
    tbl[4] = '{32'h0000_0200, 32'h0,         1'b0, 0, 0,  2, 0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 5};
    tbl[5] = '{32'h0000_0300, 32'h0F0F_0F0F, 1'b1, 2, 3,  0, 0, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, 8};
    tbl[6] = '{32'h0000_0400, 32'h0,         1'b0, 0, 7,  0, 0, 32'h7777_0007, 1'b0, 32'h7777_0007, 1'b0, 10};
    tbl[7] = '{32'h0000_0500, 32'h0,         1'b0, 1, 20, 0, 0, 32'h0000_0001, 1'b0, 32'h0,         1'b1, 11};
    tbl[8] = '{32'h0000_0600, 32'h0,         1'b0, 0, 0,  0, 4, 32'h600D_0008, 1'b0, 32'h600D_0008, 1'b0, 7};

    rst_n = 1'b0;
    slave_PADDR = '0; slave_PWDATA = '0; slave_PWRITE = 1'b0;
    slave_PSEL = 1'b0; slave_PENABLE = 1'b0;
    data_gnt_i = 1'b0; data_r_valid_i = 1'b0; data_r_rdata_i = '0;
    data_r_opc_i = 1'b0; data_r_aux_i = '0; data_r_ID_i = '0;
    repeat (3) @(negedge clk);
    check_rst("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_xfer(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      v.addr    = $urandom;
      v.wdata   = $urandom;
      v.wr      = 1'($urandom);
      v.gd      = $urandom_range(0, 4);
      v.rd      = $urandom_range(0, 6);
      v.nbad    = $urandom_range(0, 3);
      v.late_at = stale ? $urandom_range(1, 4) : 0;
      v.rdata   = $urandom;
      v.opc     = 1'($urandom);
      model(v, stale);
      run_xfer(v, $sformatf("rnd%0d", i));
    end

    // Abort a read while it waits for r_valid
    slave_PSEL = 1'b1; slave_PENABLE = 1'b0;
    slave_PADDR = 32'h0000_0700; slave_PWRITE = 1'b0; slave_PWDATA = 32'h0;
    @(negedge clk);
    slave_PENABLE = 1'b1;
    check("abort_req", {31'd0, data_req_o}, 32'd1);
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_rst("abort");
    @(negedge clk);
    rst_n = 1'b1;
    slave_PSEL = 1'b0; slave_PENABLE = 1'b0;
    stale = 1'b0;
    @(negedge clk);

    v = '{32'h0000_0704, 32'h0, 1'b0, 0, 1, 0, 0, 32'h5EC0_0D01, 1'b0, 32'h0, 1'b0, 0};
    model(v, stale);
    run_xfer(v, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
